// File: rtl/hidden_layer_sequencer_if.sv
// Bus bundle for hidden_layer_sequencer: input vector stream, weight-memory port,
// neuron operand/result wires, output result stream and status.
interface hidden_layer_sequencer_if #(
   parameter int unsigned ADDR_W = 7,
   parameter int unsigned IDX_W  = 3
);
   localparam int unsigned VEC_W  = 64;
   localparam int unsigned BYTE_W = 8;

   logic              in_valid;
   logic              in_ready;
   logic [VEC_W-1:0]  in_data;

   logic              w_rd_en;
   logic [ADDR_W-1:0] w_addr;
   logic [BYTE_W-1:0] w_rdata;

   logic [VEC_W-1:0]  nx;
   logic [VEC_W-1:0]  nw;
   logic [BYTE_W-1:0] nbias;
   logic [BYTE_W-1:0] n_out;

   logic              out_valid;
   logic              out_ready;
   logic [BYTE_W-1:0] out_data;
   logic [IDX_W-1:0]  out_idx;

   logic              busy;
   logic              layer_done;

   // Sequencer side
   modport master (
      input  in_valid, in_data, w_rdata, n_out, out_ready,
      output in_ready, w_rd_en, w_addr, nx, nw, nbias,
             out_valid, out_data, out_idx, busy, layer_done
   );

   // Environment side: vector source, weight memory, neuron, result consumer
   modport slave (
      output in_valid, in_data, w_rdata, n_out, out_ready,
      input  in_ready, w_rd_en, w_addr, nx, nw, nbias,
             out_valid, out_data, out_idx, busy, layer_done
   );
endinterface

// File: rtl/hidden_layer_sequencer.sv
// Time-multiplexes one external combinational neuron across NUM_NEURONS logical
// neurons: fetch 8 weights + bias per neuron, capture its output, stream results.
module hidden_layer_sequencer #(
   parameter int unsigned NUM_NEURONS = 8,
   parameter int unsigned ADDR_W      = 7,
   parameter int unsigned IDX_W       = 3
) (
   input  logic                      clk,
   input  logic                      rst_n,
   hidden_layer_sequencer_if.master  io
);
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned VEC_W  = 64;
   localparam int unsigned SLOTS  = 9;
   localparam int unsigned CNT_W  = 4;

   localparam logic [CNT_W-1:0] LAST_RD = CNT_W'(SLOTS - 1);
   localparam logic [CNT_W-1:0] LAST_WR = CNT_W'(SLOTS);
   localparam logic [CNT_W-1:0] BIAS_SL = CNT_W'(SLOTS - 1);
   localparam logic [IDX_W-1:0] LAST_N  = IDX_W'(NUM_NEURONS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EVAL  = 2'd2,
      EMIT  = 2'd3
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] n;
   logic [CNT_W-1:0] slot_c;

   // Read data arriving in FETCH cycle c belongs to the read issued at c-1
   assign slot_c = cnt - CNT_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         n             <= '0;
         io.in_ready   <= 1'b0;
         io.w_rd_en    <= 1'b0;
         io.w_addr     <= '0;
         io.nx         <= '0;
         io.nw         <= '0;
         io.nbias      <= '0;
         io.out_valid  <= 1'b0;
         io.out_data   <= '0;
         io.out_idx    <= '0;
         io.busy       <= 1'b0;
         io.layer_done <= 1'b0;
      end else begin
         io.layer_done <= 1'b0;
         case (state)
            IDLE: begin
               if (io.in_valid && io.in_ready) begin
                  io.nx       <= io.in_data;
                  n           <= '0;
                  cnt         <= '0;
                  io.w_addr   <= '0;
                  io.w_rd_en  <= 1'b1;
                  io.in_ready <= 1'b0;
                  io.busy     <= 1'b1;
                  state       <= FETCH;
               end else begin
                  io.in_ready <= 1'b1;
               end
            end

            FETCH: begin
               if (cnt != '0) begin
                  if (slot_c == BIAS_SL) begin
                     io.nbias <= io.w_rdata;
                  end else begin
                     io.nw[{slot_c[2:0], 3'b000} +: BYTE_W] <= io.w_rdata;
                  end
               end
               // Running address: after the last read it already points at the next neuron
               if (cnt <= LAST_RD) begin
                  io.w_addr <= io.w_addr + ADDR_W'(1);
               end
               if (cnt == LAST_RD) begin
                  io.w_rd_en <= 1'b0;
               end
               if (cnt == LAST_WR) begin
                  state <= EVAL;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            EVAL: begin
               io.out_data  <= io.n_out;
               io.out_idx   <= n;
               io.out_valid <= 1'b1;
               state        <= EMIT;
            end

            EMIT: begin
               if (io.out_ready) begin
                  io.out_valid <= 1'b0;
                  if (n == LAST_N) begin
                     io.layer_done <= 1'b1;
                     io.in_ready   <= 1'b1;
                     io.busy       <= 1'b0;
                     state         <= IDLE;
                  end else begin
                     n          <= n + IDX_W'(1);
                     cnt        <= '0;
                     io.w_rd_en <= 1'b1;
                     state      <= FETCH;
                  end
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Operand vector width is fixed by the neuron; keep the constant referenced
   logic unused_c;
   assign unused_c = ^{VEC_W'(0)};

endmodule

// File: tb/tb_hidden_layer_sequencer.sv
// Self-checking bench for hidden_layer_sequencer: weight-memory and neuron models,
// scoreboard of expected results, table-driven layers plus handshake/reset corners.
module tb_hidden_layer_sequencer;
   localparam int unsigned NUM_NEURONS = 2;
   localparam int unsigned ADDR_W      = 7;
   localparam int unsigned IDX_W       = 3;
   localparam int unsigned NWORDS      = 9 * NUM_NEURONS;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hidden_layer_sequencer_if #(.ADDR_W(ADDR_W), .IDX_W(IDX_W)) io ();

   hidden_layer_sequencer #(
      .NUM_NEURONS(NUM_NEURONS),
      .ADDR_W     (ADDR_W),
      .IDX_W      (IDX_W)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .io   (io)
   );

   // Synchronous weight memory, one-cycle read latency
   logic [7:0] mem [NWORDS];
   always @(posedge clk) begin
      if (io.w_rd_en && int'(io.w_addr) < int'(NWORDS))
         io.w_rdata <= mem[io.w_addr];
   end

   // Reference neuron: signed MAC + bias, ReLU, saturate at 127
   function automatic logic [7:0] neuron(input logic [63:0] x, input logic [63:0] w,
                                         input logic [7:0] b);
      int acc;
      acc = int'($signed(b));
      for (int i = 0; i < 8; i++)
         acc += int'($signed(x[i*8 +: 8])) * int'($signed(w[i*8 +: 8]));
      if (acc < 0) return 8'd0;
      if (acc > 127) return 8'd127;
      return 8'(acc);
   endfunction

   always_comb io.n_out = neuron(io.nx, io.nw, io.nbias);

   typedef struct {
      logic [63:0] x;
      logic [7:0]  w0, b0, w1, b1;
      logic [7:0]  e0, e1;
   } vec_t;

   typedef struct packed {
      logic [7:0]       d;
      logic [IDX_W-1:0] i;
   } exp_t;

   vec_t       tbl [6];
   exp_t       sb [$];
   int         checks   = 0;
   int         failures = 0;
   logic [7:0] cur_e0, cur_e1;
   int         cyc_cnt, stalls, reads, exp_addr, done_cnt;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   task automatic fill(input logic [7:0] w0, input logic [7:0] b0,
                       input logic [7:0] w1, input logic [7:0] b1);
      for (int k = 0; k < 8; k++) begin
         mem[k]     = w0;
         mem[9 + k] = w1;
      end
      mem[8]  = b0;
      mem[17] = b1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_nx"}, io.nx, 64'd0);
      chk({tag, "_nw"}, io.nw, 64'd0);
      chk({tag, "_ctl"}, 64'({io.in_ready, io.w_rd_en, io.w_addr, io.nbias, io.out_valid,
                               io.out_data, io.out_idx, io.busy, io.layer_done}), 64'd0);
   endtask

   // Observes every cycle at the falling edge; owns the scoreboard and layer bookkeeping
   task automatic monitor();
      logic             pv_valid, pv_ready, pv_done;
      logic [7:0]       pv_data;
      logic [IDX_W-1:0] pv_idx;
      exp_t             e;
      int               base;
      pv_valid = 1'b0; pv_ready = 1'b0; pv_done = 1'b0; pv_data = '0; pv_idx = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pv_valid = 1'b0;
            pv_done  = 1'b0;
            continue;
         end
         cyc_cnt++;
         if (pv_valid && !pv_ready) begin
            chk("bp_valid_hold", io.out_valid, 1);
            chk("bp_data_hold", io.out_data, pv_data);
            chk("bp_idx_hold", io.out_idx, pv_idx);
         end
         if (io.out_valid) begin
            chk("no_read_in_emit", io.w_rd_en, 0);
            chk("busy_in_emit", io.busy, 1);
            if (!io.out_ready) stalls++;
         end
         if (io.w_rd_en) begin
            chk("w_addr_seq", io.w_addr, exp_addr);
            exp_addr++;
            reads++;
         end
         if (io.out_valid && !pv_valid) begin
            base = 9 * int'(io.out_idx);
            for (int k = 0; k < 8; k++)
               chk("nw_slot", io.nw[k*8 +: 8], mem[base + k]);
            chk("nbias_load", io.nbias, mem[base + 8]);
         end
         if (io.out_valid && io.out_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_result", 64'(io.out_data), 64'hDEAD);
            end else begin
               e = sb.pop_front();
               chk("out_data", io.out_data, e.d);
               chk("out_idx", io.out_idx, e.i);
            end
         end
         if (io.layer_done) begin
            chk("done_single_cycle", pv_done, 0);
            chk("done_latency", cyc_cnt, 12 * NUM_NEURONS + 1 + stalls);
            chk("reads_per_layer", reads, NWORDS);
            done_cnt++;
         end
         if (io.in_valid && io.in_ready) begin
            chk("accept_not_busy", io.busy, 0);
            cyc_cnt = 0; stalls = 0; reads = 0; exp_addr = 0;
            sb.push_back('{d: cur_e0, i: IDX_W'(0)});
            sb.push_back('{d: cur_e1, i: IDX_W'(1)});
         end
         pv_valid = io.out_valid; pv_ready = io.out_ready; pv_done = io.layer_done;
         pv_data  = io.out_data;  pv_idx   = io.out_idx;
      end
   endtask

   task automatic send(input logic [63:0] x, input logic [7:0] e0, input logic [7:0] e1);
      logic ok;
      cur_e0 = e0;
      cur_e1 = e1;
      @(posedge clk); #1;
      io.in_data  = x;
      io.in_valid = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 100 && !ok; k++) begin
         @(negedge clk);
         if (io.in_ready) ok = 1'b1;
      end
      if (!ok) chk("accept_timeout", 0, 1);
      @(posedge clk); #1;
      io.in_valid = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int  base;
      logic seen;
      base = done_cnt;
      seen = 1'b0;
      for (int k = 0; k < 300 && !seen; k++) begin
         @(negedge clk);
         if (done_cnt > base) seen = 1'b1;
      end
      if (!seen) chk({name, "_timeout"}, 0, 1);
   endtask

   initial begin
      int   acc;
      logic dflag, found;

      tbl[0] = '{64'h0807060504030201, 8'h01, 8'h00, 8'h01, 8'h00, 8'd36, 8'd36};
      tbl[1] = '{64'h0807060504030201, 8'hFF, 8'h00, 8'h02, 8'h05, 8'd0,  8'd77};
      tbl[2] = '{64'h1010101010101010, 8'h00, 8'h7F, 8'h01, 8'hF6, 8'd127, 8'd118};
      tbl[3] = '{64'h0102030405060708, 8'h03, 8'h80, 8'hFE, 8'h64, 8'd0,  8'd28};
      tbl[4] = '{64'hFFFFFFFFFFFFFFFF, 8'hFD, 8'h03, 8'h01, 8'h20, 8'd27, 8'd24};
      tbl[5] = '{64'h2020202020202020, 8'h01, 8'h00, 8'h00, 8'h33, 8'd127, 8'd51};

      io.in_valid = 1'b0; io.in_data = '0; io.out_ready = 1'b1; io.w_rdata = '0;
      cyc_cnt = 0; stalls = 0; reads = 0; exp_addr = 0; done_cnt = 0;
      cur_e0 = '0; cur_e1 = '0;
      fill(8'h00, 8'h00, 8'h00, 8'h00);
      fork monitor(); join_none

      // Reset values, then in_ready rises once out of reset
      repeat (3) @(negedge clk);
      check_reset_outputs("rst_init");
      rst_n = 1'b1;
      @(negedge clk);
      chk("in_ready_after_rst", io.in_ready, 1);

      // Table-driven layers with free-flowing output
      for (int i = 0; i < 6; i++) begin
         fill(tbl[i].w0, tbl[i].b0, tbl[i].w1, tbl[i].b1);
         send(tbl[i].x, tbl[i].e0, tbl[i].e1);
         wait_done("tbl_done");
      end

      // Distinct per-address weights expose any slot or address slip
      for (int a = 0; a < int'(NWORDS); a++) mem[a] = 8'(a);
      send(64'h0100000000000001, 8'd15, 8'd42);
      @(negedge clk);
      chk("first_rd_en", io.w_rd_en, 1);
      chk("first_addr", io.w_addr, 0);
      wait_done("addr_done");

      // Backpressure: five stalled EMIT cycles on neuron 0
      fill(tbl[0].w0, tbl[0].b0, tbl[0].w1, tbl[0].b1);
      io.out_ready = 1'b0;
      send(tbl[0].x, tbl[0].e0, tbl[0].e1);
      found = 1'b0;
      for (int k = 0; k < 100 && !found; k++) begin
         @(negedge clk);
         if (io.out_valid) found = 1'b1;
      end
      chk("bp_reach_emit", found, 1);
      repeat (4) @(negedge clk);
      @(posedge clk); #1;
      io.out_ready = 1'b1;
      @(negedge clk);
      chk("bp_transfer_valid", io.out_valid, 1);
      @(negedge clk);
      chk("bp_resume_rd_en", io.w_rd_en, 1);
      chk("bp_resume_addr", io.w_addr, 9);
      wait_done("bp_done");

      // Reset in neuron 1 FETCH c=4
      send(tbl[0].x, tbl[0].e0, tbl[0].e1);
      found = 1'b0;
      for (int k = 0; k < 100 && !found; k++) begin
         @(negedge clk);
         if (io.w_rd_en && io.w_addr == ADDR_W'(13)) found = 1'b1;
      end
      chk("rst_reach_n1_c4", found, 1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("in_ready_after_mid_rst", io.in_ready, 1);
      fill(tbl[1].w0, tbl[1].b0, tbl[1].w1, tbl[1].b1);
      send(tbl[1].x, tbl[1].e0, tbl[1].e1);
      @(negedge clk);
      chk("rst_restart_rd_en", io.w_rd_en, 1);
      chk("rst_restart_addr", io.w_addr, 0);
      wait_done("rst_done");

      // in_valid held across two layers: second accept lands on the layer_done cycle
      fill(tbl[0].w0, tbl[0].b0, tbl[0].w1, tbl[0].b1);
      cur_e0 = tbl[0].e0;
      cur_e1 = tbl[0].e1;
      @(posedge clk); #1;
      io.in_data  = tbl[0].x;
      io.in_valid = 1'b1;
      acc = 0;
      dflag = 1'b0;
      for (int k = 0; k < 200 && acc < 2; k++) begin
         @(negedge clk);
         if (io.in_valid && io.in_ready) begin
            acc++;
            dflag = io.layer_done;
         end
      end
      @(posedge clk); #1;
      io.in_valid = 1'b0;
      chk("cont_accepts", acc, 2);
      chk("cont_accept_in_done", dflag, 1);
      wait_done("cont_done");

      repeat (3) @(negedge clk);
      chk("sb_empty", sb.size(), 0);
      chk("done_count", done_cnt, 11);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/hidden_layer_sequencer.md
# hidden_layer_sequencer

Time-multiplexes one hidden-layer `neuron` datapath across `NUM_NEURONS` logical neurons.
- Accepts an 8-element activation vector over a valid/ready handshake and holds it on the neuron's x inputs.
- For each logical neuron, fetches the 8 weights and bias from a synchronous weight memory, lets the combinational neuron settle, and captures its ReLU output.
- Streams the results out in neuron order over a second valid/ready handshake.
- Sits between the input-vector source and the output-layer logic; the neuron instance and the weight memory are external to this block.

## Interface
- `NUM_NEURONS`, default 8: logical neurons per layer; must be ≥ 1.
- `ADDR_W`, default 7: weight-memory address width; must satisfy 2^ADDR_W ≥ 9·NUM_NEURONS.
- `IDX_W`, default 3: output index width; must satisfy 2^IDX_W ≥ NUM_NEURONS.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: asynchronous active-low reset.
- `in_valid` in 1: input activation vector valid.
- `in_ready` out 1: block can accept a vector.
- `in_data` in 64: x1 in [7:0] through x8 in [63:56].
- `w_rd_en` out 1: weight-memory read strobe.
- `w_addr` out ADDR_W: weight-memory address.
- `w_rdata` in 8: read data, valid 1 cycle after `w_rd_en`.
- `nx` out 64: to neuron x1..x8, same packing as `in_data`.
- `nw` out 64: to neuron w1..w8, same packing.
- `nbias` out 8: to neuron bias.
- `n_out` in 8: neuron `out_val`.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_data` out 8: captured neuron output.
- `out_idx` out IDX_W: logical neuron index of `out_data`.
- `busy` out 1: high in any state except IDLE.
- `layer_done` out 1: one-cycle pulse after the last result is accepted.

## Operation
- FSM states: IDLE, FETCH, EVAL, EMIT.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: latch `in_data` into `nx`, clear neuron index n and address counter, go to FETCH.
- FETCH, local counter c=0..9:
  - For c=0..8: `w_rd_en`=1 and `w_addr`=9·n+c. The address comes from a running counter that increments per read, not from a multiplier.
  - For c=1..9: write `w_rdata` into slot c−1. Slots 0..7 are `nw` bytes w1..w8; slot 8 is `nbias`.
  - After c=9, go to EVAL.
- EVAL (1 cycle):
  - `nx`/`nw`/`nbias` are stable and the neuron has settled.
  - Register `n_out`→`out_data` and n→`out_idx`, then go to EMIT.
- EMIT:
  - `out_valid`=1.
  - On `out_ready`:
    - If n=NUM_NEURONS−1: pulse `layer_done` on the next cycle and go to IDLE.
    - Otherwise: n←n+1 and go to FETCH, with the address counter continuing at 9·(n+1).
- `nx` holds its value for the whole layer. `nw`/`nbias` hold their values until overwritten in the next FETCH.
- `out_data`/`out_idx` must not change while `out_valid`=1 and `out_ready`=0.
- `in_valid` outside IDLE is ignored: `in_ready`=0, no stall and no corruption.
- The block does no arithmetic on data. All MAC, overflow and ReLU behaviour belongs to the neuron.

## Timing
- Reset values: every output 0, i.e. `in_ready`, `w_rd_en`, `w_addr`, `nx`, `nw`, `nbias`, `out_valid`, `out_data`, `out_idx`, `busy`, `layer_done`. One exception: `in_ready` goes to 1 in the first cycle after `rst_n` deasserts, because the FSM is in IDLE.
- Input handshake to first `w_rd_en`: 1 cycle (FETCH c=0 is the cycle after acceptance).
- Per neuron: 10 FETCH + 1 EVAL + ≥1 EMIT, so minimum 12 cycles. Minimum layer time is 12·NUM_NEURONS cycles, plus 1 to return to IDLE.
- `out_ready` held high in the first EMIT cycle: `out_valid` lasts exactly 1 cycle.
- `layer_done` asserts in the first IDLE cycle, coincident with `in_ready`=1. A new vector may be accepted in that same cycle.
- `rst_n` low mid-layer: immediate asynchronous return to IDLE with all outputs 0.
  - No partial result is emitted.
  - After release, the next accepted vector restarts at neuron 0 with address 0.
- NUM_NEURONS=1: EMIT acceptance goes straight to IDLE.

## Test plan
- Weight memory all w=1, bias=0; x=1..8; NUM_NEURONS=2; `out_ready`=1 → two results, both `out_data`=36 (0x24), with `out_idx`=0 then 1. `layer_done` pulses once, 25 cycles after acceptance.
- Neuron 0 weights all 0xFF (−1), bias 0; x=1..8 → `out_data`=0 from ReLU, `out_idx`=0.
- Address check: `w_addr` over the layer must read 0..17 contiguously, each with `w_rd_en`=1 for exactly one cycle, and `nbias` must load from address 8 (neuron 0) and 17 (neuron 1).
- Backpressure: hold `out_ready`=0 for 5 cycles in EMIT → `out_valid`, `out_data`, `out_idx` stable; no new `w_rd_en`; resumes FETCH the cycle after `out_ready`=1.
- Assert `rst_n`=0 during neuron 1 FETCH at c=4 → all outputs 0 immediately. After release, a new vector yields `out_idx`=0 first, with `w_addr` starting at 0.
- `in_valid` held high continuously across two layers → second vector accepted in the `layer_done` cycle; no vector accepted while `busy`=1.
